mul8u_dot_acc: RTL and testbench

//  Dot-product wrapper around an exact 8x8 unsigned combinational multiplier.

---
 rtl/mul8u_dot_pkg.sv | 15 +
 rtl/mul8u_dot_sat_add.sv | 22 ++
 rtl/mul8u_dot_acc.sv | 128 ++++++++++++
 tb/tb_mul8u_dot_acc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul8u_dot_pkg.sv
// rtl/mul8u_dot_pkg.sv - shared widths and vector state type for the dot-product accumulator
package mul8u_dot_pkg;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  // IDLE: no vector open; ACCUM: at least one non-last term of a vector accepted
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/mul8u_dot_sat_add.sv
// rtl/mul8u_dot_sat_add.sv - saturating add of a 16-bit product into the accumulator
module mul8u_dot_sat_add
  import mul8u_dot_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  logic [ACC_W:0] full;

  // one extra bit catches the carry; on carry the sum pins to all-ones
  always_comb begin
    full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    sat  = full[ACC_W];
    sum  = sat ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  end

endmodule

// File: rtl/mul8u_dot_acc.sv
// rtl/mul8u_dot_acc.sv - streaming dot-product accumulator around an external 8x8 multiplier
module mul8u_dot_acc
  import mul8u_dot_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  logic              s1_valid;
  logic              s1_last;
  logic              s1_adv;
  logic              in_fire;
  logic              consume;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic              acc_sat;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              ovf;
  state_t            state;

  // Only a last term waiting on a blocked output can hold S1; non-last terms always drain.
  assign s1_adv   = !(s1_last && out_valid && !out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign consume  = s1_valid && s1_adv;

  // Product is masked when S1 is empty so an undriven multiplier output cannot leak in.
  assign prod    = s1_valid ? mul_o : {PROD_W{1'b0}};
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + {{(CNT_W - 1){1'b0}}, 1'b1};

  mul8u_dot_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc  (acc),
    .prod (prod),
    .sum  (acc_sum),
    .sat  (acc_sat)
  );

  // S1 operand register feeding the external multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_last  <= in_last;
      mul_a    <= in_a;
      mul_b    <= in_b;
    end else if (consume) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 running sum, term count and sticky overflow; cleared as a last term closes the vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (consume) begin
      if (s1_last) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt_inc;
        ovf <= ovf | acc_sat;
      end
    end
  end

  // Result register; a new result may replace one being accepted on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (consume && s1_last) begin
      out_valid <= 1'b1;
      out_sum   <= acc_sum;
      out_count <= cnt_inc;
      out_ovf   <= ovf | acc_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Vector tracking: a freshly opened vector wins over closing the previous one on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire && !in_last) state <= ACCUM;
        end
        ACCUM: begin
          if (consume && s1_last && !(in_fire && !in_last)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8u_dot_acc.sv
// tb/tb_mul8u_dot_acc.sv - randomized and directed bench with a scoreboard model
module tb_mul8u_dot_acc;
  import mul8u_dot_pkg::*;

  typedef struct {
    longint sum;
    longint cnt;
    longint ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_ovf;
  logic [7:0]  mul_a, mul_b, out_count;
  logic [15:0] mul_o;
  logic [23:0] out_sum;

  logic        in_ready16, out_valid16, out_ovf16;
  logic [7:0]  mul_a16, mul_b16, out_count16;
  logic [15:0] mul_o16;
  logic [15:0] out_sum16;

  int     n_tests = 0;
  int     n_fail = 0;
  bit     in_fire = 1'b0;
  longint run_sum = 0;
  longint run_n = 0;
  res_t   q24[$];
  res_t   q16[$];

  assign mul_o   = 16'(mul_a) * 16'(mul_b);
  assign mul_o16 = 16'(mul_a16) * 16'(mul_b16);

  always #5 clk = ~clk;

  mul8u_dot_acc #(.ACC_W(24), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  mul8u_dot_acc #(.ACC_W(16), .CNT_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_o(mul_o16),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_sum(out_sum16), .out_count(out_count16), .out_ovf(out_ovf16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t expect_for(input longint s, input longint n, input int w);
    res_t   r;
    longint max_v;
    max_v = (longint'(1) << w) - 1;
    r.sum = (s > max_v) ? max_v : s;
    r.ovf = (s > max_v) ? 1 : 0;
    r.cnt = (n > 255) ? 255 : n;
    return r;
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    res_t e;
    @(negedge clk);
    in_fire = 1'b0;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q24.size() == 0) check("spurious_out24", 1, 0);
        else begin
          e = q24.pop_front();
          check("sum24", 64'(out_sum), e.sum);
          check("cnt24", 64'(out_count), e.cnt);
          check("ovf24", 64'(out_ovf), e.ovf);
        end
      end
      if (out_valid16 && out_ready) begin
        if (q16.size() == 0) check("spurious_out16", 1, 0);
        else begin
          e = q16.pop_front();
          check("sum16", 64'(out_sum16), e.sum);
          check("cnt16", 64'(out_count16), e.cnt);
          check("ovf16", 64'(out_ovf16), e.ovf);
        end
      end
      if (in_valid && in_ready) begin
        in_fire = 1'b1;
        run_sum += longint'(in_a) * longint'(in_b);
        run_n++;
        if (in_last) begin
          q24.push_back(expect_for(run_sum, run_n, 24));
          q16.push_back(expect_for(run_sum, run_n, 16));
          run_sum = 0;
          run_n = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int a, input int b, input bit last);
    int waited = 0;
    in_a = a[7:0];
    in_b = b[7:0];
    in_last = last;
    in_valid = 1'b1;
    do begin
      cycle();
      waited++;
    end while (!in_fire && waited < 200);
    if (!in_fire) check("put_timeout", 0, 1);
  endtask

  task automatic drain();
    int waited = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q24.size() != 0 || q16.size() != 0 || out_valid || out_valid16) && waited < 100) begin
      cycle();
      waited++;
    end
    check("drain_q24", q24.size(), 0);
    check("drain_q16", q16.size(), 0);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    run_sum = 0;
    run_n = 0;
    q24.delete();
    q16.delete();
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    int sent;
    int vec_left;
    int guard;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    rst = 1'b0;
    cycle();
    check("rst_in_ready", in_ready, 1);

    // 1) three-term vector, in_valid held high, result two edges after the last pair is presented
    put(3, 4, 0);
    put(5, 6, 0);
    put(7, 8, 1);
    in_valid = 1'b0;
    check("t1_not_yet", out_valid, 0);
    cycle();
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 98);
    check("t1_count", out_count, 3);
    check("t1_ovf", out_ovf, 0);
    drain();

    // 2) single-term vector never opens ACCUM
    put(255, 255, 1);
    in_valid = 1'b0;
    check("t2_state_a", u_dut.state, IDLE);
    cycle();
    check("t2_state_b", u_dut.state, IDLE);
    check("t2_sum", out_sum, 65025);
    check("t2_count", out_count, 1);
    drain();

    // 3) saturation on the 16-bit instance, exact on the 24-bit one
    put(255, 255, 0);
    put(255, 255, 1);
    in_valid = 1'b0;
    cycle();
    check("t3_sum16", out_sum16, 65535);
    check("t3_ovf16", out_ovf16, 1);
    check("t3_count16", out_count16, 2);
    check("t3_sum24", out_sum, 130050);
    check("t3_ovf24", out_ovf, 0);
    drain();

    // 4) output stall with the next vector's last term parked in S1
    out_ready = 1'b0;
    put(10, 10, 1);
    put(3, 3, 0);
    put(4, 4, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready", in_ready, 0);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_sum", out_sum, 100);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    check("t4_second_valid", out_valid, 1);
    check("t4_second_sum", out_sum, 25);
    drain();

    // 5) back-to-back single-term vectors at full rate
    for (int i = 0; i < 8; i++) begin
      put($urandom_range(0, 255), $urandom_range(0, 255), 1);
      if (i >= 1) check("t5_every_cycle", out_valid, 1);
    end
    drain();

    // 6) reset in the middle of a vector discards the partial sum
    put(9, 9, 0);
    put(8, 8, 0);
    apply_reset();
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_mul_a", mul_a, 0);
    put(2, 2, 1);
    in_valid = 1'b0;
    cycle();
    check("t6_sum", out_sum, 4);
    check("t6_count", out_count, 1);
    drain();

    // random traffic against the scoreboard
    sent = 0;
    vec_left = 0;
    guard = 0;
    in_valid = 1'b0;
    while (sent < 10000 && guard < 60000) begin
      if (!in_valid && $urandom_range(0, 9) < 7) begin
        if (vec_left == 0) vec_left = $urandom_range(1, 6);
        in_a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        in_b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        in_last = (vec_left == 1);
        vec_left--;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      guard++;
      if (in_fire) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check("rand_sent", sent, 10000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
